// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder
// Description : Single-outstanding word-addressed data memory responder.
//               A request is accepted in IDLE, waits LATENCY cycles, then the
//               memory operation completes on the edge entering RESP. The
//               response is held until the initiator consumes it.
// Parameters  : DEPTH   - memory size in 32-bit words (power of two, 2..1024)
//               LATENCY - cycles from accept edge to resp_valid (1..15)
// Ports       : clk, reset (sync, active high)
//               req_valid/req_ready/req_write/req_addr/req_wdata - request
//               resp_valid/resp_ready/resp_rdata/resp_err       - response
// Options     : DMEM_ALIGN_CHECK_EN - when defined, addresses with nonzero
//               byte offset bits complete with resp_err=1 and no write.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
    parameter int DEPTH   = 8,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int         AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] WAIT       = 2'd1;
    localparam logic [1:0] RESP       = 2'd2;
    localparam logic [3:0] COUNT_LOAD = 4'(LATENCY - 1);

    logic [1:0]    state;
    logic [3:0]    count;
    logic          op_write;
    logic [31:0]   op_addr;
    logic [31:0]   op_wdata;
    logic [31:0]   mem [DEPTH];
    logic [31:0]   rdata_q;
    logic          err_q;

    logic          accept;
    logic          enter_resp;
    logic          out_of_range;
    logic          misaligned;
    logic          op_err;
    logic [AW-1:0] op_index;

    // Held low during reset so no request can look accepted while the
    // block is being cleared.
    assign req_ready  = (state == IDLE) && !reset;
    assign accept     = req_valid && req_ready;
    assign enter_resp = (state == WAIT) && (count == 4'd0);

    assign op_index     = op_addr[AW+1:2];
    assign out_of_range = {2'b00, op_addr[31:2]} >= 32'(DEPTH);

`ifdef DMEM_ALIGN_CHECK_EN
    assign misaligned = (op_addr[1:0] != 2'b00);
`else
    // Byte offset bits are deliberately dropped in this build.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^op_addr[1:0];
    assign misaligned       = 1'b0;
`endif

    assign op_err = out_of_range || misaligned;

    // Response outputs are cleared on every exit from RESP, so they read
    // as zero in every other state without extra gating.
    assign resp_valid = (state == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            count    <= 4'd0;
            op_write <= 1'b0;
            op_addr  <= 32'd0;
            op_wdata <= 32'd0;
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 32'd0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_write <= req_write;
                        op_addr  <= req_addr;
                        op_wdata <= req_wdata;
                        // LATENCY=1 still passes through WAIT with a zero
                        // count for one cycle, so resp_valid always rises
                        // exactly LATENCY edges after the accept edge.
                        count    <= COUNT_LOAD;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (count == 4'd0) begin
                        state <= RESP;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state   <= IDLE;
                        rdata_q <= 32'd0;
                        err_q   <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    count <= 4'd0;
                end
            endcase

            // Memory side effect happens only on the edge entering RESP, so
            // a reset during WAIT cancels the operation entirely.
            if (enter_resp) begin
                if (op_err) begin
                    rdata_q <= 32'd0;
                    err_q   <= 1'b1;
                end else if (op_write) begin
                    mem[op_index] <= op_wdata;
                    rdata_q       <= 32'd0;
                    err_q         <= 1'b0;
                end else begin
                    rdata_q <= mem[op_index];
                    err_q   <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_responder
// Description : Self-checking bench for data_mem_responder. A cycle-count
//               model predicts the handshake outputs of the LATENCY=2 unit on
//               every cycle; directed transactions carry literal expectations.
//               A second LATENCY=1 instance checks the short-latency timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

    localparam int LAT = 2;
`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;

    logic        v1, rdy1, w1, rv1, rr1, er1;
    logic [31:0] a1, d1, rd1;

    data_mem_responder #(.DEPTH(8), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    data_mem_responder #(.DEPTH(8), .LATENCY(1)) dut1 (
        .clk(clk), .reset(reset),
        .req_valid(v1), .req_ready(rdy1), .req_write(w1),
        .req_addr(a1), .req_wdata(d1),
        .resp_valid(rv1), .resp_ready(rr1),
        .resp_rdata(rd1), .resp_err(er1)
    );

    int total = 0;
    int bad   = 0;

    function void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // ------------------------------------------------------------------
    // Model: counts edges; a request accepted at edge acc becomes visible
    // after edge acc+LAT, where its memory effect is applied.
    // ------------------------------------------------------------------
    int          e = 0;
    bit          pending = 1'b0;
    int          acc = 0;
    bit          m_write;
    logic [31:0] m_addr, m_wdata;
    logic [31:0] xr = 32'd0;
    bit          xe = 1'b0;
    logic [31:0] mm [8];
    int          idx;
    bit          m_err;
    bit          chk_on = 1'b0;

    always @(posedge clk) begin
        e = e + 1;
        if (reset) begin
            pending = 1'b0;
            xr = 32'd0;
            xe = 1'b0;
            foreach (mm[i]) mm[i] = 32'd0;
        end else if (pending) begin
            if (e == acc + LAT) begin
                idx   = int'(m_addr >> 2);
                m_err = (idx >= 8) || (ALIGN && (m_addr[1:0] != 2'b00));
                if (m_err) begin
                    xr = 32'd0; xe = 1'b1;
                end else if (m_write) begin
                    mm[idx] = m_wdata; xr = 32'd0; xe = 1'b0;
                end else begin
                    xr = mm[idx]; xe = 1'b0;
                end
            end else if ((e - 1 >= acc + LAT) && resp_ready) begin
                pending = 1'b0;
                xr = 32'd0;
                xe = 1'b0;
            end
        end else if (req_valid) begin
            pending = 1'b1;
            acc     = e;
            m_write = req_write;
            m_addr  = req_addr;
            m_wdata = req_wdata;
        end
    end

    bit exp_valid;
    always @(negedge clk) begin
        if (chk_on) begin
            exp_valid = pending && (e >= acc + LAT);
            chk("m_req_ready",  {31'd0, req_ready},  {31'd0, !pending && !reset});
            chk("m_resp_valid", {31'd0, resp_valid}, {31'd0, exp_valid});
            chk("m_resp_rdata", resp_rdata, exp_valid ? xr : 32'd0);
            chk("m_resp_err",   {31'd0, resp_err},   {31'd0, exp_valid && xe});
        end
    end

    // One complete transaction on the main unit with literal expectations.
    task automatic do_req(input bit w, input logic [31:0] a, input logic [31:0] d,
                          input int hold, input bit pulse,
                          input logic [31:0] exp_rd, input bit exp_er);
        int t;
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
        t = 0;
        while (!req_ready && t < 50) begin @(posedge clk); #1; t++; end
        if (!req_ready) begin
            chk("accept_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        // Scramble request fields while busy; they must have no effect.
        req_valid = 1'b0; req_write = 1'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        t = 0;
        while (!resp_valid && t < 40) begin @(posedge clk); #1; t++; end
        if (!resp_valid) begin
            chk("resp_timeout", 32'd0, 32'd1);
            return;
        end
        chk("latency",    t, LAT);
        chk("rsp_rdata",  resp_rdata, exp_rd);
        chk("rsp_err",    {31'd0, resp_err}, {31'd0, exp_er});
        for (int i = 0; i < hold; i++) begin
            if (pulse) begin
                req_valid = (i % 2 == 0); req_write = 1'b1;
                req_addr = 32'd0; req_wdata = 32'h1234_5678;
            end
            @(posedge clk); #1;
            chk("hold_valid", {31'd0, resp_valid}, 32'd1);
            chk("hold_rdata", resp_rdata, exp_rd);
            chk("hold_err",   {31'd0, resp_err}, {31'd0, exp_er});
            chk("hold_ready", {31'd0, req_ready}, 32'd0);
        end
        req_valid = 1'b0; resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk("post_hs_ready", {31'd0, req_ready}, 32'd1);
        chk("post_hs_valid", {31'd0, resp_valid}, 32'd0);
    endtask

    // Transaction on the LATENCY=1 unit.
    task automatic req1(input bit w, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rd);
        int t;
        v1 = 1'b1; w1 = w; a1 = a; d1 = d;
        chk("l1_ready", {31'd0, rdy1}, 32'd1);
        @(posedge clk); #1;
        v1 = 1'b0;
        t = 0;
        while (!rv1 && t < 40) begin @(posedge clk); #1; t++; end
        chk("l1_latency", t, 1);
        chk("l1_rdata", rd1, exp_rd);
        chk("l1_err", {31'd0, er1}, 32'd0);
        rr1 = 1'b1;
        @(posedge clk); #1;
        rr1 = 1'b0;
        chk("l1_post_valid", {31'd0, rv1}, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        resp_ready = 1'b0;
        v1 = 1'b0; w1 = 1'b0; a1 = 32'd0; d1 = 32'd0; rr1 = 1'b0;

        @(posedge clk); #1;
        chk_on = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_err",   {31'd0, resp_err}, 32'd0);
        reset = 1'b0;
        #1;
        chk("rel_ready", {31'd0, req_ready}, 32'd1);

        // Store then load back
        do_req(1'b1, 32'h04, 32'hDEAD_BEEF, 0, 1'b0, 32'd0, 1'b0);
        do_req(1'b0, 32'h04, 32'h0, 0, 1'b0, 32'hDEAD_BEEF, 1'b0);

        // Out-of-range load, then every word is intact
        do_req(1'b0, 32'h20, 32'h0, 0, 1'b0, 32'd0, 1'b1);
        do_req(1'b1, 32'h40, 32'hFFFF_FFFF, 0, 1'b0, 32'd0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            do_req(1'b0, 32'(i * 4), 32'h0, 0, 1'b0,
                   (i == 1) ? 32'hDEAD_BEEF : 32'd0, 1'b0);
        end

        // Back-pressure with ignored request pulses
        do_req(1'b0, 32'h04, 32'h0, 5, 1'b1, 32'hDEAD_BEEF, 1'b0);
        do_req(1'b0, 32'h00, 32'h0, 0, 1'b0, 32'd0, 1'b0);

        // Reset one cycle after a store is accepted
        do_req(1'b1, 32'h1C, 32'h7777_0001, 0, 1'b0, 32'd0, 1'b0);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h00; req_wdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        req_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            chk("abort_valid", {31'd0, resp_valid}, 32'd0);
        end
        do_req(1'b0, 32'h00, 32'h0, 0, 1'b0, 32'd0, 1'b0);
        do_req(1'b0, 32'h04, 32'h0, 0, 1'b0, 32'd0, 1'b0);
        do_req(1'b0, 32'h1C, 32'h0, 0, 1'b0, 32'd0, 1'b0);

        // Misaligned store
        do_req(1'b1, 32'h06, 32'h0BAD_F00D, 0, 1'b0, 32'd0, ALIGN);
        do_req(1'b0, 32'h04, 32'h0, 0, 1'b0, ALIGN ? 32'd0 : 32'h0BAD_F00D, 1'b0);

        // LATENCY=1 instance
        req1(1'b1, 32'h08, 32'h55AA_55AA, 32'd0);
        req1(1'b0, 32'h08, 32'h0, 32'h55AA_55AA);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
